// File: rtl/bind_stream_source.sv
// ---------------------------------------------------------------------------
// bind_stream_source
//
// Upstream stimulus stage for bind-scope regression tests. After a start it
// emits COUNT words on a valid/ready handshake. The first word is SEED and
// each accepted word is followed by the previous word plus STEP, wrapping
// modulo 2**WIDTH. A completion flag, a transfer count and a running XOR
// checksum of the accepted words let a bound checker verify the stream
// without any outside reference.
//
// Ports:
//   clk         sole clock, all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   start       begins a run when sampled high in IDLE or DONE
//   data_o      word currently offered
//   valid_o     data_o is valid
//   ready_i     consumer accepts data_o this cycle
//   done_o      run complete
//   sent_o      words accepted in the current or last run
//   checksum_o  XOR of words accepted in the current or last run
//
// COUNT must be less than 2**CNTW so that the last index fits the counter.
// ---------------------------------------------------------------------------
module bind_stream_source #(
   parameter int unsigned WIDTH = 32,
   parameter logic [31:0] SEED  = 32'h12345678,
   parameter logic [31:0] STEP  = 32'h00000001,
   parameter int unsigned COUNT = 8,
   parameter int unsigned CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             done_o,
   output logic [CNTW-1:0]  sent_o,
   output logic [WIDTH-1:0] checksum_o
);

   // SEED and STEP are given as 32-bit values and truncated to the word width.
   localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
   localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
   // Counter value held while the final word is being offered. Unused when
   // COUNT is zero because RUN is never entered then.
   localparam logic [CNTW-1:0]  LAST_IDX  = CNTW'(COUNT - 1);
   localparam bit               EMPTY_RUN = (COUNT == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_reg,    state_next;
   logic [WIDTH-1:0] data_reg,     data_next;
   logic             valid_reg,    valid_next;
   logic             done_reg,     done_next;
   logic [CNTW-1:0]  sent_reg,     sent_next;
   logic [WIDTH-1:0] checksum_reg, checksum_next;

   logic             xfer;
   logic             last_xfer;
   logic [WIDTH-1:0] checksum_upd;

   // A word moves only while RUN is offering it and the consumer takes it.
   assign xfer      = (state_reg == ST_RUN) && valid_reg && ready_i;
   assign last_xfer = xfer && (sent_reg == LAST_IDX);

   // Running checksum folded in bit by bit with the word being accepted.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cks
         assign checksum_upd[gi] = checksum_reg[gi] ^ data_reg[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         data_reg     <= '0;
         valid_reg    <= 1'b0;
         done_reg     <= 1'b0;
         sent_reg     <= '0;
         checksum_reg <= '0;
      end else begin
         state_reg    <= state_next;
         data_reg     <= data_next;
         valid_reg    <= valid_next;
         done_reg     <= done_next;
         sent_reg     <= sent_next;
         checksum_reg <= checksum_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = EMPTY_RUN ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // start is deliberately ignored while a run is in flight.
            if (last_xfer) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output register next values. Everything holds unless changed below,
   // which keeps data/valid stable under backpressure.
   // ------------------------------------------------------------------
   always_comb begin
      data_next     = data_reg;
      valid_next    = valid_reg;
      done_next     = done_reg;
      sent_next     = sent_reg;
      checksum_next = checksum_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sent_next     = '0;
               checksum_next = '0;
               if (EMPTY_RUN) begin
                  // Nothing to send: report completion immediately.
                  valid_next = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  data_next  = SEED_W;
                  valid_next = 1'b1;
                  done_next  = 1'b0;
               end
            end
         end
         ST_RUN: begin
            if (xfer) begin
               sent_next     = sent_reg + 1'b1;
               checksum_next = checksum_upd;
               // Wraps silently; after the last word the value is don't-care.
               data_next     = data_reg + STEP_W;
               if (last_xfer) begin
                  valid_next = 1'b0;
                  done_next  = 1'b1;
               end
            end
         end
         default: begin
            valid_next = 1'b0;
            done_next  = 1'b0;
         end
      endcase
   end

   assign data_o     = data_reg;
   assign valid_o    = valid_reg;
   assign done_o     = done_reg;
   assign sent_o     = sent_reg;
   assign checksum_o = checksum_reg;

endmodule

// File: tb/tb_bind_stream_source.sv
// ---------------------------------------------------------------------------
// tb_bind_stream_source
//
// Three instances share clk and rst_n: a COUNT=4 main stream, a COUNT=3
// stream starting near the top of the word range, and a COUNT=0 stream.
// Expected words are queued when a run is started and popped as the
// consumer accepts them.
// ---------------------------------------------------------------------------
module tb_bind_stream_source;

   localparam int W = 32;
   localparam int C = 8;
   localparam logic [W-1:0] SEED_M = 32'h12345678;
   localparam logic [W-1:0] SEED_W = 32'hFFFFFFFE;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic         start_m = 1'b0, ready_m = 1'b1;
   logic [W-1:0] data_m, cks_m;
   logic         valid_m, done_m;
   logic [C-1:0] sent_m;

   logic         start_w = 1'b0, ready_w = 1'b1;
   logic [W-1:0] data_w, cks_w;
   logic         valid_w, done_w;
   logic [C-1:0] sent_w;

   logic         start_z = 1'b0, ready_z = 1'b1;
   logic [W-1:0] data_z, cks_z;
   logic         valid_z, done_z;
   logic [C-1:0] sent_z;

   logic [W-1:0] q_m[$];
   logic [W-1:0] q_w[$];

   int checks_total = 0;
   int checks_passed = 0;

   always #5 clk = ~clk;

   bind_stream_source #(.WIDTH(W), .SEED(32'h12345678), .STEP(32'h1),
                        .COUNT(4), .CNTW(C)) dut_m (
      .clk(clk), .rst_n(rst_n), .start(start_m), .data_o(data_m),
      .valid_o(valid_m), .ready_i(ready_m), .done_o(done_m),
      .sent_o(sent_m), .checksum_o(cks_m));

   bind_stream_source #(.WIDTH(W), .SEED(32'hFFFFFFFE), .STEP(32'h1),
                        .COUNT(3), .CNTW(C)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start_w), .data_o(data_w),
      .valid_o(valid_w), .ready_i(ready_w), .done_o(done_w),
      .sent_o(sent_w), .checksum_o(cks_w));

   bind_stream_source #(.WIDTH(W), .SEED(32'h12345678), .STEP(32'h1),
                        .COUNT(0), .CNTW(C)) dut_z (
      .clk(clk), .rst_n(rst_n), .start(start_z), .data_o(data_z),
      .valid_o(valid_z), .ready_i(ready_z), .done_o(done_z),
      .sent_o(sent_z), .checksum_o(cks_z));

   task automatic check_eq(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Consumer-side monitors, sampled on the falling edge while inputs are
   // stable. Inputs are driven 1 time unit after each rising edge.
   always @(negedge clk) begin
      if (valid_m) begin
         if (q_m.size() == 0) begin
            check_eq("m_unexpected_valid", valid_m, 1'b0);
         end else if (ready_m) begin
            logic [W-1:0] exp;
            exp = q_m.pop_front();
            check_eq("m_word", data_m, exp);
            $display("main word accepted 0x%08h (expected 0x%08h)", data_m, exp);
         end else begin
            check_eq("m_hold", data_m, q_m[0]);
            $display("main word held 0x%08h under backpressure", data_m);
         end
      end
      if (valid_w) begin
         if (q_w.size() == 0) begin
            check_eq("w_unexpected_valid", valid_w, 1'b0);
         end else if (ready_w) begin
            logic [W-1:0] exp;
            exp = q_w.pop_front();
            check_eq("w_word", data_w, exp);
            $display("wrap word accepted 0x%08h (expected 0x%08h)", data_w, exp);
         end
      end
      if (valid_z) begin
         check_eq("z_valid_never", valid_z, 1'b0);
      end
   end

   // One main-instance run. ready_pat bit i is ready during the i-th cycle
   // after the start edge; poke_start pulses start again mid-run.
   task automatic run_main(input string name, input logic [7:0] ready_pat,
                           input bit poke_start, input int exp_cycles);
      int cycles;
      for (int i = 0; i < 4; i++) q_m.push_back(SEED_M + W'(i));
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      check_eq({name, "_first_valid"}, valid_m, 1'b1);
      check_eq({name, "_done_low"}, done_m, 1'b0);
      check_eq({name, "_sent_clr"}, sent_m, 0);
      check_eq({name, "_cks_clr"}, cks_m, 0);
      cycles = 0;
      while (!done_m && cycles < 50) begin
         ready_m = (cycles < 8) ? ready_pat[cycles] : 1'b1;
         start_m = poke_start && (cycles == 1);
         @(posedge clk); #1;
         cycles++;
      end
      start_m = 1'b0;
      ready_m = 1'b1;
      check_eq({name, "_cycles"}, cycles, exp_cycles);
      check_eq({name, "_done"}, done_m, 1'b1);
      check_eq({name, "_valid_low"}, valid_m, 1'b0);
      check_eq({name, "_sent"}, sent_m, 4);
      check_eq({name, "_cks"}, cks_m, 32'h0);
      check_eq({name, "_queue_empty"}, q_m.size(), 0);
      $display("%s run: %0d cycles, sent=%0d checksum=0x%08h", name, cycles,
               sent_m, cks_m);
   endtask

   initial begin
      int cycles;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_data", data_m, 0);
      check_eq("rst_valid", valid_m, 0);
      check_eq("rst_done", done_m, 0);
      check_eq("rst_sent", sent_m, 0);
      check_eq("rst_cks", cks_m, 0);
      check_eq("rst_z_done", done_z, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("idle_no_valid", valid_m, 0);
      check_eq("idle_no_done", done_m, 0);

      // Straight run, then backpressure, then a run with a stray start.
      run_main("basic", 8'hFF, 1'b0, 4);
      run_main("bp", 8'b1111_1001, 1'b0, 6);
      run_main("poke", 8'hFF, 1'b1, 4);

      // Asynchronous reset after two transfers of a run.
      for (int i = 0; i < 4; i++) q_m.push_back(SEED_M + W'(i));
      start_m = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check_eq("pre_rst_sent", sent_m, 2);
      #1 rst_n = 1'b0;
      #1;
      check_eq("arst_data", data_m, 0);
      check_eq("arst_valid", valid_m, 0);
      check_eq("arst_done", done_m, 0);
      check_eq("arst_sent", sent_m, 0);
      check_eq("arst_cks", cks_m, 0);
      $display("async reset mid-run: outputs data=0x%0h valid=%0b sent=%0d",
               data_m, valid_m, sent_m);
      q_m.delete();
      #4 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("post_rst_idle_valid", valid_m, 0);
      end
      run_main("after_rst", 8'hFF, 1'b0, 4);

      // Wrapping stream.
      q_w.push_back(SEED_W);
      q_w.push_back(SEED_W + 1);
      q_w.push_back(SEED_W + 2);
      start_w = 1'b1;
      @(posedge clk); #1;
      start_w = 1'b0;
      check_eq("w_first_data", data_w, SEED_W);
      cycles = 0;
      while (!done_w && cycles < 50) begin
         @(posedge clk); #1;
         cycles++;
      end
      check_eq("w_cycles", cycles, 3);
      check_eq("w_sent", sent_w, 3);
      check_eq("w_cks", cks_w, 32'h1);
      check_eq("w_queue_empty", q_w.size(), 0);
      $display("wrap run: sent=%0d checksum=0x%08h", sent_w, cks_w);

      // Empty run.
      start_z = 1'b1;
      @(posedge clk); #1;
      start_z = 1'b0;
      check_eq("z_done", done_z, 1'b1);
      check_eq("z_valid", valid_z, 1'b0);
      check_eq("z_sent", sent_z, 0);
      check_eq("z_cks", cks_z, 0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("z_done_holds", done_z, 1'b1);
      $display("empty run: done=%0b sent=%0d", done_z, sent_z);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion",
               checks_total);
      $fatal(1);
   end

endmodule
